// File: rtl/pc_pkg.sv
// Shared definitions for the program counter unit: next-PC select codes,
// default geometry and a pointer-width helper.
package pc_pkg;

  localparam int PC_W_DEF      = 6;
  localparam int RAS_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_SEL_HOLD,
    PC_SEL_RET,
    PC_SEL_CALL,
    PC_SEL_JUMP,
    PC_SEL_BRANCH,
    PC_SEL_INC
  } pc_sel_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// so the newest RAS_DEPTH return addresses are always retained.
module pc_ras
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int PTR_W = ptr_width(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [PTR_W-1:0] top_ptr;

  // ptr_reg is the next free slot; the power-of-two depth makes it wrap naturally.
  assign top_ptr = ptr_reg - PTR_W'(1);
  assign top     = mem[top_ptr];
  assign full    = (count_reg == CNT_W'(RAS_DEPTH));
  assign empty   = (count_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
    end else if (push) begin
      ptr_reg   <= ptr_reg + PTR_W'(1);
      count_reg <= full ? count_reg : count_reg + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_reg   <= top_ptr;
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Storage is left unreset: with count at zero, stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall, jump, relative branch and (with PC_RAS_EN defined)
// call/return through a return-address stack with sticky overflow/underflow flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jump_enable,
  input  logic [PC_W-1:0] jump_value,
  input  logic            branch_enable,
  input  logic [PC_W-1:0] branch_offset,
  input  logic            call_enable,
  input  logic            ret_enable,
  output logic [PC_W-1:0] pc_count,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  if (PC_W < 2) begin : g_bad_width
    $error("pc_unit: PC_W must be at least 2");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of two, at least 2");
  end

  pc_sel_e         sel;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc   = pc_reg + PC_W'(1);
  assign pc_count = pc_reg;

`ifdef PC_RAS_EN
  logic            ras_full;
  logic            ras_empty;
  logic [PC_W-1:0] ras_top;
  logic            ovf_set;
  logic            unf_set;
  logic            ovf_reg;
  logic            unf_reg;

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (sel == PC_SEL_CALL),
    .pop       (sel == PC_SEL_RET),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`endif

  always_comb begin
    sel = PC_SEL_INC;
`ifdef PC_RAS_EN
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (stall) begin
      sel = PC_SEL_HOLD;
    end else if (ret_enable) begin
`ifdef PC_RAS_EN
      // An empty-stack return falls through to the next instruction.
      if (ras_empty) begin
        sel     = PC_SEL_INC;
        unf_set = 1'b1;
      end else begin
        sel = PC_SEL_RET;
      end
`else
      sel = PC_SEL_INC;
`endif
    end else if (call_enable) begin
`ifdef PC_RAS_EN
      sel     = PC_SEL_CALL;
      ovf_set = ras_full;
`else
      sel = PC_SEL_JUMP;
`endif
    end else if (jump_enable) begin
      sel = PC_SEL_JUMP;
    end else if (branch_enable) begin
      sel = PC_SEL_BRANCH;
    end
  end

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      PC_SEL_HOLD:   pc_next = pc_reg;
`ifdef PC_RAS_EN
      PC_SEL_RET:    pc_next = ras_top;
`endif
      PC_SEL_CALL,
      PC_SEL_JUMP:   pc_next = jump_value;
      PC_SEL_BRANCH: pc_next = pc_reg + branch_offset;
      default:       pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_VEC;
    end else begin
      pc_reg <= pc_next;
    end
  end

`ifdef PC_RAS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_reg | ovf_set;
      unf_reg <= unf_reg | unf_set;
    end
  end

  assign ras_overflow  = ovf_reg;
  assign ras_underflow = unf_reg;
`else
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

endmodule
